// File: rtl/lbuf_win_ctrl_if.sv
// Pixel-stream handshake plus line-buffer control bundle for the window sequencer.
// Pure wiring, no latency of its own.
// Back-pressure travels as the controller-driven oREADY; iSTALL carries the downstream hold.
interface lbuf_win_ctrl_if #(
   parameter int CW = 5
);
   logic          iSTART;
   logic          iVALID;
   logic          oREADY;
   logic          iSTALL;
   logic          oLB_EN;
   logic          oLB_START;
   logic          oWIN_VALID;
   logic [CW-1:0] oROW;
   logic [CW-1:0] oCOL;
   logic          oBUSY;
   logic          oDONE;

   // Pixel source / frame controller side
   modport master (
      output iSTART, iVALID, iSTALL,
      input  oREADY, oLB_EN, oLB_START, oWIN_VALID, oROW, oCOL, oBUSY, oDONE
   );

   // Window sequencer side
   modport slave (
      input  iSTART, iVALID, iSTALL,
      output oREADY, oLB_EN, oLB_START, oWIN_VALID, oROW, oCOL, oBUSY, oDONE
   );
endinterface

// File: rtl/lbuf_win_ctrl.sv
// Sequences the L_BUF line-buffer chain and flags complete KxK windows per accepted pixel.
// oLB_EN/oREADY are combinational; oWIN_VALID/oROW/oCOL appear 1 cycle after acceptance.
// Downstream iSTALL (or a pending iSTART) withholds oREADY; no pixel is consumed while low.
module lbuf_win_ctrl #(
   parameter int IMG_W = 17,
   parameter int IMG_H = 17,
   parameter int K     = 3,
   parameter int CW    = 5
) (
   input logic             iCLK,
   input logic             iRSTn,
   lbuf_win_ctrl_if.slave  bus
);

   localparam logic [CW-1:0] LAST_COL      = CW'(IMG_W - 1);
   localparam logic [CW-1:0] LAST_ROW      = CW'(IMG_H - 1);
   localparam logic [CW-1:0] FILL_LAST_ROW = CW'(K - 2);
   localparam logic [CW-1:0] WIN_MIN       = CW'(K - 1);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FILL,
      RUN,
      DONE
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] row;
   logic [CW-1:0] col;
   logic          ready;
   logic          acc;
   logic          last_col;
   logic          win_vld;
   logic [CW-1:0] win_row;
   logic [CW-1:0] win_col;

   // State register
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Handshake and next-state decode; a restart overrides everything outside IDLE
   always_comb begin
      ready     = ((state == FILL) || (state == RUN)) && !bus.iSTALL && !bus.iSTART;
      acc       = bus.iVALID && ready;
      last_col  = (col == LAST_COL);
      state_nxt = state;
      case (state)
         IDLE:    if (bus.iSTART) state_nxt = CLEAR;
         CLEAR:   state_nxt = FILL;
         FILL:    if (acc && last_col && (row == FILL_LAST_ROW)) state_nxt = RUN;
         RUN:     if (acc && last_col && (row == LAST_ROW)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (bus.iSTART && (state != IDLE)) begin
         state_nxt = CLEAR;
      end
   end

   // Pixel position counters: zeroed on (re)start, advanced only by accepted pixels
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         row <= '0;
         col <= '0;
      end else if (bus.iSTART || (state == CLEAR)) begin
         row <= '0;
         col <= '0;
      end else if (acc) begin
         if (last_col) begin
            col <= '0;
            row <= row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Window flag registered on the same edge the line buffers shift
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         win_vld <= 1'b0;
         win_row <= '0;
         win_col <= '0;
      end else if (acc) begin
         win_vld <= (row >= WIN_MIN) && (col >= WIN_MIN);
         win_row <= row;
         win_col <= col;
      end else begin
         win_vld <= 1'b0;
      end
   end

   assign bus.oREADY     = ready;
   assign bus.oLB_EN     = acc;
   assign bus.oLB_START  = (state == CLEAR);
   assign bus.oBUSY      = (state != IDLE);
   assign bus.oDONE      = (state == DONE);
   assign bus.oWIN_VALID = win_vld;
   assign bus.oROW       = win_row;
   assign bus.oCOL       = win_col;

endmodule
